// File: rtl/vc8000d_g2_hevc_intra_pkg.sv
// Shared definitions for the HEVC intra neighbour-availability sequencers:
// vector widths, sequencer states, flags field layout and z-scan helpers.
package vc8000d_g2_hevc_intra_pkg;

    localparam int unsigned STATE_W = 208;
    localparam int unsigned FLAG_W  = 33;
    localparam int unsigned TUCNT_W = 8;

    // neighbor_flags layout: {above[15:0], corner, left[15:0]}
    localparam int unsigned FLG_ABOVE_MSB = 32;
    localparam int unsigned FLG_ABOVE_LSB = 17;
    localparam int unsigned FLG_CORNER    = 16;
    localparam int unsigned FLG_LEFT_MSB  = 15;
    localparam int unsigned FLG_LEFT_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } zscan_xy_t;

    // Even index bits form the x coordinate, odd bits the y coordinate.
    function automatic zscan_xy_t zscan_deinterleave(input logic [TUCNT_W-1:0] n);
        zscan_xy_t r;
        r = '0;
        for (int unsigned i = 0; i < TUCNT_W / 2; i++) begin
            r.x[i] = n[2*i];
            r.y[i] = n[2*i+1];
        end
        return r;
    endfunction

    // log2 of a power-of-two size in 4x4 units (1..16).
    function automatic logic [2:0] log2_pow2(input logic [4:0] v);
        logic [2:0] r;
        case (v)
            5'd2:    r = 3'd1;
            5'd4:    r = 3'd2;
            5'd8:    r = 3'd3;
            5'd16:   r = 3'd4;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vc8000d_g2_hevc_zscan_tu_gen.sv
// TU walker for one CU: clamps the TU size to the CU, counts TUs in z-scan
// order and produces the current TU offset (4x4 units) and last-TU flag.
module vc8000d_g2_hevc_zscan_tu_gen
    import vc8000d_g2_hevc_intra_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       advance_i,
    input  logic [4:0] cu_4x4_i,
    input  logic [3:0] tu_size_4x4_i,
    output logic [3:0] tu_size_eff_o,
    output logic [5:0] tu_x_o,
    output logic [5:0] tu_y_o,
    output logic       last_o
);

    logic [TUCNT_W-1:0] n_q;
    logic [TUCNT_W-1:0] n_d;
    logic [2:0]         tu_lg;
    logic [2:0]         side_lg;
    logic [8:0]         tu_count;
    zscan_xy_t          xy;

    // Effective TU size, TU count and coordinates of the current TU.
    always_comb begin
        if ({1'b0, tu_size_4x4_i} < cu_4x4_i) begin
            tu_size_eff_o = tu_size_4x4_i;
        end else begin
            tu_size_eff_o = cu_4x4_i[3:0];
        end
        tu_lg    = log2_pow2({1'b0, tu_size_eff_o});
        side_lg  = log2_pow2(cu_4x4_i) - tu_lg;
        tu_count = 9'd1 << {side_lg, 1'b0};
        last_o   = ({1'b0, n_q} == (tu_count - 9'd1));
        xy       = zscan_deinterleave(n_q);
        tu_x_o   = {2'b00, xy.x} << tu_lg;
        tu_y_o   = {2'b00, xy.y} << tu_lg;
    end

    // Counter restarts on a new CU and returns to zero after the last TU.
    always_comb begin
        n_d = n_q;
        if (start_i) begin
            n_d = '0;
        end else if (advance_i) begin
            n_d = last_o ? '0 : n_q + 1'b1;
        end
    end

    // TU index register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q <= '0;
        end else begin
            n_q <= n_d;
        end
    end

endmodule

// File: rtl/vc8000d_g2_hevc_nbr_flags_lu_seq.sv
// Luma neighbour-flags sequencer: accepts a CU command, walks its TUs,
// drives the external neighbour-flags datapath, owns its state register and
// emits one registered flags word per TU over a valid/ready handshake.
module vc8000d_g2_hevc_nbr_flags_lu_seq
    import vc8000d_g2_hevc_intra_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [4:0]         cmd_ctb_size_div4,
    input  logic [6:0]         cmd_cu_size_pixel,
    input  logic [3:0]         cmd_tu_size_4x4,
    input  logic [5:0]         cmd_cu_x,
    input  logic [5:0]         cmd_cu_y,
    input  logic [10:0]        cmd_tmp_hor,
    input  logic [10:0]        cmd_tmp_ver,
    input  logic [20:0]        cmd_constrained_pred,
    input  logic [3:0]         cmd_slice_tile_info,
    output logic [4:0]         nf_ctb_size_div4,
    output logic [6:0]         nf_cu_size_pixel,
    output logic [3:0]         nf_tu_size_4x4,
    output logic [3:0]         nf_pixel_position_x_4x4,
    output logic [3:0]         nf_pixel_position_y_4x4,
    output logic [5:0]         nf_tu_x,
    output logic [5:0]         nf_tu_y,
    output logic [5:0]         nf_cu_x,
    output logic [5:0]         nf_cu_y,
    output logic [10:0]        nf_tmp_hor,
    output logic [10:0]        nf_tmp_ver,
    output logic [20:0]        nf_constrained_pred,
    output logic [3:0]         nf_slice_and_tile_info,
    output logic [STATE_W-1:0] nf_state_in,
    input  logic [STATE_W-1:0] nf_state_out,
    input  logic [FLAG_W-1:0]  nf_neighbor_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLAG_W-1:0]  out_flags,
    output logic [5:0]         out_tu_x,
    output logic [5:0]         out_tu_y,
    output logic               out_last,
    output logic               busy
);

    seq_state_e         state_q, state_d;
    logic [4:0]         ctb_q;
    logic [6:0]         cu_size_q;
    logic [3:0]         tu_size_q;
    logic [5:0]         cu_x_q, cu_y_q;
    logic [10:0]        tmp_hor_q, tmp_ver_q;
    logic [20:0]        cp_q;
    logic [3:0]         info_q;
    logic [STATE_W-1:0] nbr_state_q;
    logic               out_valid_q, out_last_q;
    logic [FLAG_W-1:0]  out_flags_q;
    logic [5:0]         out_tu_x_q, out_tu_y_q;

    logic               accept, capture, pop;
    logic [3:0]         tu_eff;
    logic [5:0]         tu_x, tu_y;
    logic               tu_last;

    assign accept  = cmd_valid & cmd_ready;
    assign capture = (state_q == RUN) & (~out_valid_q | out_ready);
    assign pop     = out_valid_q & out_ready;

    vc8000d_g2_hevc_zscan_tu_gen u_tu_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (accept),
        .advance_i     (capture),
        .cu_4x4_i      (cu_size_q[6:2]),
        .tu_size_4x4_i (tu_size_q),
        .tu_size_eff_o (tu_eff),
        .tu_x_o        (tu_x),
        .tu_y_o        (tu_y),
        .last_o        (tu_last)
    );

    // Next-state logic: one CU at a time, command port open only in IDLE.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = RUN;
            end
            RUN: begin
                if (capture && tu_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && out_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command registers, loaded on accept and held for the whole CU.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctb_q     <= '0;
            cu_size_q <= '0;
            tu_size_q <= '0;
            cu_x_q    <= '0;
            cu_y_q    <= '0;
            tmp_hor_q <= '0;
            tmp_ver_q <= '0;
            cp_q      <= '0;
            info_q    <= '0;
        end else if (accept) begin
            ctb_q     <= cmd_ctb_size_div4;
            cu_size_q <= cmd_cu_size_pixel;
            tu_size_q <= cmd_tu_size_4x4;
            cu_x_q    <= cmd_cu_x;
            cu_y_q    <= cmd_cu_y;
            tmp_hor_q <= cmd_tmp_hor;
            tmp_ver_q <= cmd_tmp_ver;
            cp_q      <= cmd_constrained_pred;
            info_q    <= cmd_slice_tile_info;
        end
    end

    // Neighbour state advances only when a TU result is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nbr_state_q <= '0;
        end else if (capture) begin
            nbr_state_q <= nf_state_out;
        end
    end

    // Output word register: capture replaces a popped or empty slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_flags_q <= '0;
            out_tu_x_q  <= '0;
            out_tu_y_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_flags_q <= nf_neighbor_flags;
            out_tu_x_q  <= tu_x;
            out_tu_y_q  <= tu_y;
            out_last_q  <= tu_last;
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

    assign nf_ctb_size_div4        = ctb_q;
    assign nf_cu_size_pixel        = cu_size_q;
    assign nf_tu_size_4x4          = tu_eff;
    assign nf_pixel_position_x_4x4 = cu_x_q[3:0] + tu_x[3:0];
    assign nf_pixel_position_y_4x4 = cu_y_q[3:0] + tu_y[3:0];
    assign nf_tu_x                 = tu_x;
    assign nf_tu_y                 = tu_y;
    assign nf_cu_x                 = cu_x_q;
    assign nf_cu_y                 = cu_y_q;
    assign nf_tmp_hor              = tmp_hor_q;
    assign nf_tmp_ver              = tmp_ver_q;
    assign nf_constrained_pred     = cp_q;
    assign nf_slice_and_tile_info  = info_q;
    assign nf_state_in             = nbr_state_q;

    assign out_valid = out_valid_q;
    assign out_flags = out_flags_q;
    assign out_tu_x  = out_tu_x_q;
    assign out_tu_y  = out_tu_y_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE) | out_valid_q;

endmodule

// File: tb/tb_vc8000d_g2_hevc_nbr_flags_lu_seq.sv
// Directed bench for the luma neighbour-flags sequencer. A stand-in datapath
// folds the drive signals into the flags word and scrambles the state vector
// so that TU order, coordinates and command fields are all observable.
module tb_vc8000d_g2_hevc_nbr_flags_lu_seq;

    typedef struct {
        int          cu_px;
        int          tsz;
        int          cux;
        int          cuy;
        int          ctb;
        logic [10:0] thor;
        logic [10:0] tver;
        logic [20:0] cp;
        logic [3:0]  info;
    } cmd_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready;
    logic [4:0]   cmd_ctb_size_div4;
    logic [6:0]   cmd_cu_size_pixel;
    logic [3:0]   cmd_tu_size_4x4;
    logic [5:0]   cmd_cu_x, cmd_cu_y;
    logic [10:0]  cmd_tmp_hor, cmd_tmp_ver;
    logic [20:0]  cmd_constrained_pred;
    logic [3:0]   cmd_slice_tile_info;
    logic [4:0]   nf_ctb_size_div4;
    logic [6:0]   nf_cu_size_pixel;
    logic [3:0]   nf_tu_size_4x4;
    logic [3:0]   nf_pixel_position_x_4x4, nf_pixel_position_y_4x4;
    logic [5:0]   nf_tu_x, nf_tu_y, nf_cu_x, nf_cu_y;
    logic [10:0]  nf_tmp_hor, nf_tmp_ver;
    logic [20:0]  nf_constrained_pred;
    logic [3:0]   nf_slice_and_tile_info;
    logic [207:0] nf_state_in, nf_state_out;
    logic [32:0]  nf_neighbor_flags;
    logic         out_valid, out_ready, out_last, busy;
    logic [32:0]  out_flags;
    logic [5:0]   out_tu_x, out_tu_y;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    logic [207:0] gstate = '0;

    logic [32:0] w_flags [0:299];
    logic [5:0]  w_x     [0:299];
    logic [5:0]  w_y     [0:299];
    logic        w_last  [0:299];
    int          w_cyc   [0:299];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vc8000d_g2_hevc_nbr_flags_lu_seq dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_ctb_size_div4       (cmd_ctb_size_div4),
        .cmd_cu_size_pixel       (cmd_cu_size_pixel),
        .cmd_tu_size_4x4         (cmd_tu_size_4x4),
        .cmd_cu_x                (cmd_cu_x),
        .cmd_cu_y                (cmd_cu_y),
        .cmd_tmp_hor             (cmd_tmp_hor),
        .cmd_tmp_ver             (cmd_tmp_ver),
        .cmd_constrained_pred    (cmd_constrained_pred),
        .cmd_slice_tile_info     (cmd_slice_tile_info),
        .nf_ctb_size_div4        (nf_ctb_size_div4),
        .nf_cu_size_pixel        (nf_cu_size_pixel),
        .nf_tu_size_4x4          (nf_tu_size_4x4),
        .nf_pixel_position_x_4x4 (nf_pixel_position_x_4x4),
        .nf_pixel_position_y_4x4 (nf_pixel_position_y_4x4),
        .nf_tu_x                 (nf_tu_x),
        .nf_tu_y                 (nf_tu_y),
        .nf_cu_x                 (nf_cu_x),
        .nf_cu_y                 (nf_cu_y),
        .nf_tmp_hor              (nf_tmp_hor),
        .nf_tmp_ver              (nf_tmp_ver),
        .nf_constrained_pred     (nf_constrained_pred),
        .nf_slice_and_tile_info  (nf_slice_and_tile_info),
        .nf_state_in             (nf_state_in),
        .nf_state_out            (nf_state_out),
        .nf_neighbor_flags       (nf_neighbor_flags),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_flags               (out_flags),
        .out_tu_x                (out_tu_x),
        .out_tu_y                (out_tu_y),
        .out_last                (out_last),
        .busy                    (busy)
    );

    // Stand-in datapath.
    assign nf_neighbor_flags = {nf_slice_and_tile_info, nf_tmp_hor[4:0], nf_pixel_position_x_4x4,
                                nf_pixel_position_y_4x4, nf_tu_x, nf_tu_y, nf_tu_size_4x4};
    assign nf_state_out = {nf_state_in[199:0], nf_state_in[207:200]} ^ {200'd0, nf_tu_x[3:0], nf_tu_y[3:0]};

    // ---------------- golden model ----------------
    function automatic int tu_eff(cmd_t c);
        int cu4;
        cu4 = c.cu_px / 4;
        return (c.tsz < cu4) ? c.tsz : cu4;
    endfunction

    function automatic int zc(int n, int odd);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) r = r | (((n >> (2*b + odd)) & 1) << b);
        return r;
    endfunction

    // {flags[32:0], tu_x[5:0], tu_y[5:0], last}
    function automatic logic [45:0] exp_word(cmd_t c, int n, int total);
        logic [5:0] tx, ty, cx, cy;
        logic [3:0] px, py, te;
        te = 4'(tu_eff(c));
        tx = 6'(zc(n, 0) * tu_eff(c));
        ty = 6'(zc(n, 1) * tu_eff(c));
        cx = 6'(c.cux);
        cy = 6'(c.cuy);
        px = cx[3:0] + tx[3:0];
        py = cy[3:0] + ty[3:0];
        return {c.info, c.thor[4:0], px, py, tx, ty, te, tx, ty, (n == total - 1)};
    endfunction

    function automatic logic [207:0] step(logic [207:0] s, cmd_t c, int n);
        logic [5:0] tx, ty;
        tx = 6'(zc(n, 0) * tu_eff(c));
        ty = 6'(zc(n, 1) * tu_eff(c));
        return {s[199:0], s[207:200]} ^ {200'd0, tx[3:0], ty[3:0]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input cmd_t c, input bit hold, output int waited, output bit tmo);
        @(negedge clk);
        cmd_ctb_size_div4    = 5'(c.ctb);
        cmd_cu_size_pixel    = 7'(c.cu_px);
        cmd_tu_size_4x4      = 4'(c.tsz);
        cmd_cu_x             = 6'(c.cux);
        cmd_cu_y             = 6'(c.cuy);
        cmd_tmp_hor          = c.thor;
        cmd_tmp_ver          = c.tver;
        cmd_constrained_pred = c.cp;
        cmd_slice_tile_info  = c.info;
        cmd_valid            = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        tmo = !cmd_ready;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Records popped words; returns after the last word, max_words, or budget.
    task automatic collect(input int max_words, input bit rnd, input int budget,
                           output int nw, output bit tmo, output int hold_bad, output int rdy_seen);
        bit           stall, done;
        logic [32:0]  sf;
        logic [5:0]   sx, sy;
        logic         sl;
        logic [207:0] ss;
        nw = 0; tmo = 1'b1; hold_bad = 0; rdy_seen = 0; stall = 1'b0; done = 1'b0;
        sf = '0; sx = '0; sy = '0; sl = 1'b0; ss = '0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (cmd_ready) rdy_seen++;
            if (stall && (!out_valid || {out_flags, out_tu_x, out_tu_y, out_last, nf_state_in} !== {sf, sx, sy, sl, ss}))
                hold_bad++;
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            stall = out_valid && !out_ready;
            if (stall) begin
                sf = out_flags; sx = out_tu_x; sy = out_tu_y; sl = out_last; ss = nf_state_in;
            end
            if (out_valid && out_ready) begin
                w_flags[nw] = out_flags; w_x[nw] = out_tu_x; w_y[nw] = out_tu_y;
                w_last[nw] = out_last; w_cyc[nw] = cyc;
                nw++;
                if (out_last || nw == max_words) begin
                    done = 1'b1;
                    tmo  = 1'b0;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0;
        cmd_ctb_size_div4 = '0; cmd_cu_size_pixel = '0; cmd_tu_size_4x4 = '0;
        cmd_cu_x = '0; cmd_cu_y = '0; cmd_tmp_hor = '0; cmd_tmp_ver = '0;
        cmd_constrained_pred = '0; cmd_slice_tile_info = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if ({out_flags, out_tu_x, out_tu_y, out_last} !== 46'd0)
            $display("FAIL rst_out_regs got %h exp 0", {out_flags, out_tu_x, out_tu_y, out_last}); else n_pass++;
        n_checks++; if (nf_state_in !== 208'd0) $display("FAIL rst_state got %h exp 0", nf_state_in); else n_pass++;
        n_checks++; if ({nf_cu_x, nf_cu_y, nf_constrained_pred, nf_tu_x, nf_tu_y} !== 45'd0)
            $display("FAIL rst_cmd_regs got %h exp 0", {nf_cu_x, nf_cu_y, nf_constrained_pred, nf_tu_x, nf_tu_y}); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_8x8();
        cmd_t c;
        int waited, nw, hb, rs;
        bit t0, t1;
        logic [5:0] ex [0:3];
        logic [5:0] ey [0:3];
        ex = '{6'd0, 6'd1, 6'd0, 6'd1};
        ey = '{6'd0, 6'd0, 6'd1, 6'd1};
        c = '{cu_px: 8, tsz: 1, cux: 0, cuy: 0, ctb: 16, thor: 11'd40, tver: 11'd36, cp: '1, info: 4'hf};
        send_cmd(c, 1'b0, waited, t0);
        collect(300, 1'b0, 50, nw, t1, hb, rs);
        n_checks++; if ({t0, t1} !== 2'b00) $display("FAIL basic_timeout got %b exp 00", {t0, t1}); else n_pass++;
        n_checks++; if (nw !== 4) $display("FAIL basic_count got %0d exp 4", nw); else n_pass++;
        n_checks++; if (w_cyc[0] !== acc_cyc + 1) $display("FAIL basic_latency got %0d exp %0d", w_cyc[0], acc_cyc + 1); else n_pass++;
        n_checks++; if (w_cyc[3] - w_cyc[0] !== 3) $display("FAIL basic_gaps got %0d exp 3", w_cyc[3] - w_cyc[0]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({w_x[i], w_y[i], w_last[i]} !== {ex[i], ey[i], (i == 3)})
                $display("FAIL basic_tu%0d got (%0d,%0d,%b) exp (%0d,%0d,%b)", i, w_x[i], w_y[i], w_last[i], ex[i], ey[i], (i == 3));
            else n_pass++;
            n_checks++;
            if ({w_flags[i], w_x[i], w_y[i], w_last[i]} !== exp_word(c, i, 4))
                $display("FAIL basic_word%0d got %h exp %h", i, {w_flags[i], w_x[i], w_y[i], w_last[i]}, exp_word(c, i, 4));
            else n_pass++;
            gstate = step(gstate, c, i);
        end
        n_checks++; if (nf_state_in !== gstate) $display("FAIL basic_state got %h exp %h", nf_state_in, gstate); else n_pass++;
        n_checks++; if ({nf_ctb_size_div4, nf_constrained_pred} !== {5'd16, 21'h1fffff})
            $display("FAIL basic_cmd_regs got %h exp %h", {nf_ctb_size_div4, nf_constrained_pred}, {5'd16, 21'h1fffff}); else n_pass++;
    endtask

    task automatic test_64x64();
        cmd_t c;
        int waited, nw, hb, rs, gaps, lasts;
        bit t0, t1;
        // TU 8: four TUs, pixel positions wrap to 4 bits from cu_x=16
        c = '{cu_px: 64, tsz: 8, cux: 16, cuy: 0, ctb: 16, thor: 11'd100, tver: 11'd90, cp: 21'h0a5a5, info: 4'h3};
        send_cmd(c, 1'b0, waited, t0);
        collect(300, 1'b0, 50, nw, t1, hb, rs);
        n_checks++; if ({t0, t1} !== 2'b00) $display("FAIL big8_timeout got %b exp 00", {t0, t1}); else n_pass++;
        n_checks++; if (nw !== 4) $display("FAIL big8_count got %0d exp 4", nw); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({w_flags[i], w_x[i], w_y[i], w_last[i]} !== exp_word(c, i, 4))
                $display("FAIL big8_word%0d got %h exp %h", i, {w_flags[i], w_x[i], w_y[i], w_last[i]}, exp_word(c, i, 4));
            else n_pass++;
            gstate = step(gstate, c, i);
        end
        n_checks++; if (nf_state_in !== gstate) $display("FAIL big8_state got %h exp %h", nf_state_in, gstate); else n_pass++;
        // TU 1: 256 TUs back to back
        c = '{cu_px: 64, tsz: 1, cux: 0, cuy: 0, ctb: 16, thor: 11'd17, tver: 11'd17, cp: 21'h1, info: 4'h9};
        send_cmd(c, 1'b0, waited, t0);
        collect(300, 1'b0, 400, nw, t1, hb, rs);
        n_checks++; if ({t0, t1} !== 2'b00) $display("FAIL big1_timeout got %b exp 00", {t0, t1}); else n_pass++;
        n_checks++; if (nw !== 256) $display("FAIL big1_count got %0d exp 256", nw); else n_pass++;
        gaps = 0; lasts = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0 && w_cyc[i] != w_cyc[i-1] + 1) gaps++;
            if (w_last[i] === 1'b1) lasts++;
            n_checks++;
            if ({w_flags[i], w_x[i], w_y[i], w_last[i]} !== exp_word(c, i, 256))
                $display("FAIL big1_word%0d got %h exp %h", i, {w_flags[i], w_x[i], w_y[i], w_last[i]}, exp_word(c, i, 256));
            else n_pass++;
            gstate = step(gstate, c, i);
        end
        n_checks++; if (gaps !== 0) $display("FAIL big1_gaps got %0d exp 0", gaps); else n_pass++;
        n_checks++; if (lasts !== 1) $display("FAIL big1_last_count got %0d exp 1", lasts); else n_pass++;
        n_checks++; if (nf_state_in !== gstate) $display("FAIL big1_state got %h exp %h", nf_state_in, gstate); else n_pass++;
    endtask

    task automatic test_backpressure();
        cmd_t c;
        int waited, nw, hb, rs;
        bit t0, t1;
        c = '{cu_px: 16, tsz: 1, cux: 8, cuy: 12, ctb: 8, thor: 11'd22, tver: 11'd30, cp: 21'h12345, info: 4'h6};
        send_cmd(c, 1'b0, waited, t0);
        collect(300, 1'b1, 300, nw, t1, hb, rs);
        out_ready = 1'b1;
        n_checks++; if ({t0, t1} !== 2'b00) $display("FAIL bp_timeout got %b exp 00", {t0, t1}); else n_pass++;
        n_checks++; if (nw !== 16) $display("FAIL bp_count got %0d exp 16", nw); else n_pass++;
        n_checks++; if (hb !== 0) $display("FAIL bp_hold got %0d changed stalls exp 0", hb); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({w_flags[i], w_x[i], w_y[i], w_last[i]} !== exp_word(c, i, 16))
                $display("FAIL bp_word%0d got %h exp %h", i, {w_flags[i], w_x[i], w_y[i], w_last[i]}, exp_word(c, i, 16));
            else n_pass++;
            gstate = step(gstate, c, i);
        end
        n_checks++; if (nf_state_in !== gstate) $display("FAIL bp_state got %h exp %h", nf_state_in, gstate); else n_pass++;
    endtask

    task automatic test_clamp();
        cmd_t c;
        int waited, nw, hb, rs;
        bit t0, t1;
        c = '{cu_px: 16, tsz: 8, cux: 4, cuy: 4, ctb: 16, thor: 11'd8, tver: 11'd8, cp: 21'h0, info: 4'h1};
        send_cmd(c, 1'b0, waited, t0);
        collect(300, 1'b0, 50, nw, t1, hb, rs);
        n_checks++; if ({t0, t1} !== 2'b00) $display("FAIL clamp_timeout got %b exp 00", {t0, t1}); else n_pass++;
        n_checks++; if (nw !== 1) $display("FAIL clamp_count got %0d exp 1", nw); else n_pass++;
        n_checks++; if ({w_flags[0], w_x[0], w_y[0], w_last[0]} !== exp_word(c, 0, 1))
            $display("FAIL clamp_word got %h exp %h", {w_flags[0], w_x[0], w_y[0], w_last[0]}, exp_word(c, 0, 1)); else n_pass++;
        gstate = step(gstate, c, 0);
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL clamp_drain_ready got %b exp 0", cmd_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if ({cmd_ready, busy, out_valid} !== 3'b100 || cyc !== acc_cyc + 2)
            $display("FAIL clamp_idle got rdy/busy/vld %b at +%0d exp 100 at +2", {cmd_ready, busy, out_valid}, cyc - acc_cyc); else n_pass++;
        n_checks++; if (nf_state_in !== gstate) $display("FAIL clamp_state got %h exp %h", nf_state_in, gstate); else n_pass++;
    endtask

    task automatic test_mid_reset();
        cmd_t c;
        int waited, nw, hb, rs;
        bit t0, t1;
        c = '{cu_px: 16, tsz: 1, cux: 0, cuy: 0, ctb: 16, thor: 11'd50, tver: 11'd50, cp: 21'h7, info: 4'h2};
        send_cmd(c, 1'b0, waited, t0);
        collect(5, 1'b0, 50, nw, t1, hb, rs);
        n_checks++; if (nw !== 5) $display("FAIL mrst_partial got %0d exp 5", nw); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, cmd_ready, busy, out_last} !== 4'b0100)
            $display("FAIL mrst_ctrl got vld/rdy/busy/last %b exp 0100", {out_valid, cmd_ready, busy, out_last}); else n_pass++;
        n_checks++; if (nf_state_in !== 208'd0) $display("FAIL mrst_state got %h exp 0", nf_state_in); else n_pass++;
        rst_n = 1'b1;
        gstate = '0;
        c = '{cu_px: 8, tsz: 1, cux: 2, cuy: 2, ctb: 4, thor: 11'd6, tver: 11'd6, cp: 21'h3, info: 4'hc};
        send_cmd(c, 1'b0, waited, t0);
        collect(300, 1'b0, 50, nw, t1, hb, rs);
        n_checks++; if (nw !== 4) $display("FAIL mrst_new_count got %0d exp 4", nw); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({w_flags[i], w_x[i], w_y[i], w_last[i]} !== exp_word(c, i, 4))
                $display("FAIL mrst_word%0d got %h exp %h", i, {w_flags[i], w_x[i], w_y[i], w_last[i]}, exp_word(c, i, 4));
            else n_pass++;
            gstate = step(gstate, c, i);
        end
        n_checks++; if (nf_state_in !== gstate) $display("FAIL mrst_state got %h exp %h", nf_state_in, gstate); else n_pass++;
    endtask

    task automatic test_back_to_back();
        cmd_t a, b;
        int waited, nw, hb, rs, last_cyc;
        bit t0, t1;
        a = '{cu_px: 8, tsz: 1, cux: 4, cuy: 4, ctb: 16, thor: 11'd12, tver: 11'd12, cp: 21'h55, info: 4'h5};
        b = '{cu_px: 16, tsz: 4, cux: 8, cuy: 8, ctb: 16, thor: 11'd31, tver: 11'd29, cp: 21'haa, info: 4'ha};
        send_cmd(a, 1'b1, waited, t0);
        collect(300, 1'b0, 50, nw, t1, hb, rs);
        n_checks++; if (nw !== 4) $display("FAIL b2b_a_count got %0d exp 4", nw); else n_pass++;
        n_checks++; if (rs !== 0) $display("FAIL b2b_overlap got %0d ready cycles exp 0", rs); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({w_flags[i], w_x[i], w_y[i], w_last[i]} !== exp_word(a, i, 4))
                $display("FAIL b2b_a_word%0d got %h exp %h", i, {w_flags[i], w_x[i], w_y[i], w_last[i]}, exp_word(a, i, 4));
            else n_pass++;
            gstate = step(gstate, a, i);
        end
        last_cyc = w_cyc[3];
        send_cmd(b, 1'b0, waited, t0);
        n_checks++; if (waited !== 0 || acc_cyc !== last_cyc + 2)
            $display("FAIL b2b_accept got wait %0d at +%0d exp wait 0 at +2", waited, acc_cyc - last_cyc); else n_pass++;
        collect(300, 1'b0, 50, nw, t1, hb, rs);
        n_checks++; if (nw !== 1) $display("FAIL b2b_b_count got %0d exp 1", nw); else n_pass++;
        n_checks++; if ({w_flags[0], w_x[0], w_y[0], w_last[0]} !== exp_word(b, 0, 1))
            $display("FAIL b2b_b_word got %h exp %h", {w_flags[0], w_x[0], w_y[0], w_last[0]}, exp_word(b, 0, 1)); else n_pass++;
        gstate = step(gstate, b, 0);
        n_checks++; if (nf_state_in !== gstate) $display("FAIL b2b_state got %h exp %h", nf_state_in, gstate); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_8x8();
        test_64x64();
        test_backpressure();
        test_clamp();
        test_mid_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
